// File: rtl/obj_pkg.sv
// Shared types and helpers for the object-ROM fetch scheduler.
//   fetch_state_e : scheduler FSM states
//   ROW_BYTES     : bytes per 16-px 4bpp tile row (one ROM beat)
//   bank_ofs()    : code-bank offset for a bank index, from the bank register
package obj_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } fetch_state_e;

   localparam int ROW_BYTES = 8;
   localparam int CODE_W    = 13;
   localparam int ROW_W     = 4;

   // Bank 0 is fixed at offset 0; banks 1..3 take their nibble plus one,
   // so a nibble of 0xF reaches offset 0x10 (hence 5 bits).
   function automatic logic [4:0] bank_ofs(input logic [15:0] ctrl,
                                           input logic [1:0]  bank);
      logic [4:0] ofs;
      case (bank)
         2'd1:    ofs = {1'b0, ctrl[3:0]}  + 5'd1;
         2'd2:    ofs = {1'b0, ctrl[7:4]}  + 5'd1;
         2'd3:    ofs = {1'b0, ctrl[11:8]} + 5'd1;
         default: ofs = 5'd0;
      endcase
      return ofs;
   endfunction

endpackage

// File: rtl/obj_rr_arbiter.sv
// Round-robin request picker.
//   req   : request vector
//   ptr   : index with highest priority this round
//   grant : one-hot grant (zero when no request)
//   idx   : binary index of the granted requester
//   any   : at least one request present
module obj_rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      logic found;
      int   j;
      grant = '0;
      idx   = '0;
      any   = |req;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/obj_rom_fetch_sched.sv
// Shares one sprite-ROM read port between NUM_REQ object-engine requesters.
// Owns the code-bank register, translates 13-bit codes to ROM byte
// addresses, arbitrates round-robin and keeps a one-entry last-row cache.
//   clk, reset                 : clock, synchronous active-high reset
//   cs_n, cpu_ds_n, cpu_rw, din: CPU write port for the bank register
//   req, req_code, req_row     : per-requester fetch requests
//   ack, rd_data               : one-cycle ack per requester, shared data
//   rom_req, rom_addr          : ROM read request / address
//   rom_ack, rom_data          : ROM completion pulse / data
//
// state  | meaning
// IDLE   | wait for a request, grant one round-robin and latch it
// LOOKUP | form address, check cache; hit -> RESP, miss -> issue ROM read
// WAIT   | hold ROM request until rom_ack
// RESP   | ack pulse to the granted requester, advance RR pointer
module obj_rom_fetch_sched
   import obj_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 27,
   parameter int DATA_W  = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cs_n,
   input  logic [1:0]                cpu_ds_n,
   input  logic                      cpu_rw,
   input  logic [15:0]               din,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*CODE_W-1:0] req_code,
   input  logic [NUM_REQ*ROW_W-1:0]  req_row,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      rom_req,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic                      rom_ack,
   input  logic [DATA_W-1:0]         rom_data
);

   localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int ROW_SHIFT = $clog2(ROW_BYTES);

   fetch_state_e       state;
   logic [15:0]        ctrl;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   g_idx;
   logic [CODE_W-1:0]  g_code;
   logic [ROW_W-1:0]   g_row;
   logic               cache_vld;
   logic [ADDR_W-1:0]  cache_tag;
   logic [DATA_W-1:0]  cache_data;
   // set by any bank write since grant: the returning row must not be cached
   logic               no_cache;

   logic [NUM_REQ-1:0] arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;

   logic               bank_wr;
   logic [4:0]         ofs;
   logic [18:0]        code_mod;
   logic [31:0]        addr_full;
   logic [ADDR_W-1:0]  addr;
   logic               cache_hit;

   obj_rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   assign bank_wr   = ~cs_n & ~cpu_rw;
   assign ofs       = bank_ofs(ctrl, g_code[12:11]);
   assign code_mod  = {3'b000, ofs, g_code[10:0]};
   assign addr_full = 32'({code_mod, g_row}) << ROW_SHIFT;
   assign addr      = ADDR_W'(addr_full);
   // a bank write in LOOKUP already counts as an invalidation
   assign cache_hit = cache_vld && (cache_tag == addr) && !bank_wr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ctrl       <= '0;
         rr_ptr     <= '0;
         g_idx      <= '0;
         g_code     <= '0;
         g_row      <= '0;
         cache_vld  <= 1'b0;
         cache_tag  <= '0;
         cache_data <= '0;
         no_cache   <= 1'b0;
         ack        <= '0;
         rd_data    <= '0;
         rom_req    <= 1'b0;
         rom_addr   <= '0;
      end else begin
         ack <= '0;
         if (bank_wr) begin
            if (!cpu_ds_n[1]) ctrl[15:8] <= din[15:8];
            if (!cpu_ds_n[0]) ctrl[7:0]  <= din[7:0];
         end
         case (state)
            IDLE: begin
               if (arb_any) begin
                  g_idx    <= arb_idx;
                  g_code   <= req_code[int'(arb_idx)*CODE_W +: CODE_W];
                  g_row    <= req_row[int'(arb_idx)*ROW_W +: ROW_W];
                  no_cache <= 1'b0;
                  state    <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (cache_hit) begin
                  rd_data <= cache_data;
                  ack     <= NUM_REQ'(1) << g_idx;
                  state   <= RESP;
               end else begin
                  rom_req  <= 1'b1;
                  rom_addr <= addr;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (rom_ack) begin
                  rd_data <= rom_data;
                  rom_req <= 1'b0;
                  ack     <= NUM_REQ'(1) << g_idx;
                  state   <= RESP;
                  if (!no_cache) begin
                     cache_vld  <= 1'b1;
                     cache_tag  <= rom_addr;
                     cache_data <= rom_data;
                  end
               end
            end
            RESP: begin
               rr_ptr <= (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + IDX_W'(1);
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // placed last so it overrides any capture in the same cycle
         if (bank_wr) begin
            cache_vld <= 1'b0;
            no_cache  <= 1'b1;
         end
      end
   end

endmodule
